// File: rtl/text_console.sv
// Text console writer: turns a character stream into writes to a text-mode
// video memory (char at byte 2i, attribute at byte 2i+1), handling CR, LF,
// BS, FF (clear) and scrolling when the cursor runs off the last row.
module text_console #(
   parameter int          COLS  = 80,
   parameter int          ROWS  = 25,
   parameter logic [7:0]  BLANK = 8'h20
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        wr,
   input  logic [7:0]  char_in,
   input  logic [7:0]  attr_in,
   output logic        busy,
   output logic [11:0] vaddr,
   output logic [7:0]  vdata_out,
   output logic        vwe,
   input  logic [7:0]  vdata_in,
   output logic [10:0] cursor
);

   localparam logic [10:0] COLS_W         = 11'(COLS);
   localparam logic [10:0] LAST_ROW       = 11'(ROWS - 1);
   localparam logic [10:0] LAST_CELL      = 11'(COLS * ROWS - 1);
   localparam logic [10:0] LAST_ROW_START = 11'(COLS * (ROWS - 1));
   localparam logic [11:0] ROW_BYTES      = 12'(2 * COLS);
   localparam logic [11:0] LAST_COPY      = 12'(2 * COLS * (ROWS - 1) - 1);

   localparam logic [7:0] CODE_BS = 8'h08;
   localparam logic [7:0] CODE_LF = 8'h0A;
   localparam logic [7:0] CODE_FF = 8'h0C;
   localparam logic [7:0] CODE_CR = 8'h0D;

   typedef enum logic [2:0] {IDLE, PUTC, PUTA, SRD, SWR, FILC, FILA} state_t;

   state_t      state, state_nx;
   logic [10:0] cursor_nx;
   logic [11:0] idx, idx_nx;
   logic [7:0]  char_q, char_nx;
   logic [7:0]  attr_q, attr_nx;
   logic [11:0] vaddr_nx;
   logic [7:0]  vdata_nx;
   logic        vwe_nx;
   logic [10:0] row;
   logic [10:0] row_start;

   // Row of the cursor and the cell index where that row begins.
   always_comb begin
      row       = cursor / COLS_W;
      row_start = 11'(row * COLS_W);
   end

   assign busy = (state != IDLE);

   // State, cursor, latched operands and the registered memory port.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         cursor    <= '0;
         idx       <= '0;
         char_q    <= '0;
         attr_q    <= '0;
         vaddr     <= '0;
         vdata_out <= '0;
         vwe       <= 1'b0;
      end else begin
         state     <= state_nx;
         cursor    <= cursor_nx;
         idx       <= idx_nx;
         char_q    <= char_nx;
         attr_q    <= attr_nx;
         vaddr     <= vaddr_nx;
         vdata_out <= vdata_nx;
         vwe       <= vwe_nx;
      end
   end

   // Next-state logic; memory port values are computed one cycle ahead so
   // that the registered outputs line up with the state they belong to.
   always_comb begin
      state_nx  = state;
      cursor_nx = cursor;
      idx_nx    = idx;
      char_nx   = char_q;
      attr_nx   = attr_q;
      vaddr_nx  = vaddr;
      vdata_nx  = vdata_out;
      vwe_nx    = 1'b0;
      case (state)
         IDLE: begin
            if (wr) begin
               char_nx = char_in;
               attr_nx = attr_in;
               if (char_in >= 8'h20) begin
                  state_nx = PUTC;
                  vwe_nx   = 1'b1;
                  vaddr_nx = {cursor, 1'b0};
                  vdata_nx = char_in;
               end else begin
                  case (char_in)
                     CODE_CR: cursor_nx = row_start;
                     CODE_LF: begin
                        if (row < LAST_ROW) begin
                           cursor_nx = row_start + COLS_W;
                        end else begin
                           state_nx = SRD;
                           idx_nx   = '0;
                           vaddr_nx = ROW_BYTES;
                        end
                     end
                     CODE_BS: begin
                        if (cursor != '0) cursor_nx = cursor - 11'd1;
                     end
                     CODE_FF: begin
                        state_nx = FILC;
                        idx_nx   = '0;
                        vwe_nx   = 1'b1;
                        vaddr_nx = '0;
                        vdata_nx = BLANK;
                     end
                     default: ;
                  endcase
               end
            end
         end
         PUTC: begin
            state_nx = PUTA;
            vwe_nx   = 1'b1;
            vaddr_nx = {cursor, 1'b1};
            vdata_nx = attr_q;
         end
         PUTA: begin
            if (cursor == LAST_CELL) begin
               state_nx = SRD;
               idx_nx   = '0;
               vaddr_nx = ROW_BYTES;
            end else begin
               cursor_nx = cursor + 11'd1;
               state_nx  = IDLE;
            end
         end
         SRD: begin
            state_nx = SWR;
            vwe_nx   = 1'b1;
            vaddr_nx = idx;
            vdata_nx = vdata_in;
         end
         SWR: begin
            if (idx == LAST_COPY) begin
               state_nx = FILC;
               idx_nx   = {1'b0, LAST_ROW_START};
               vwe_nx   = 1'b1;
               vaddr_nx = {LAST_ROW_START, 1'b0};
               vdata_nx = BLANK;
            end else begin
               state_nx = SRD;
               idx_nx   = idx + 12'd1;
               vaddr_nx = idx + 12'd1 + ROW_BYTES;
            end
         end
         FILC: begin
            state_nx = FILA;
            vwe_nx   = 1'b1;
            vaddr_nx = {idx[10:0], 1'b1};
            vdata_nx = attr_q;
         end
         FILA: begin
            if (idx[10:0] == LAST_CELL) begin
               state_nx  = IDLE;
               cursor_nx = (char_q == CODE_FF) ? 11'd0 : LAST_ROW_START;
            end else begin
               state_nx = FILC;
               idx_nx   = idx + 12'd1;
               vwe_nx   = 1'b1;
               vaddr_nx = {idx[10:0] + 11'd1, 1'b0};
               vdata_nx = BLANK;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_text_console.sv
// Directed bench for text_console with a behavioural video memory attached.
module tb_text_console;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        wr = 1'b0;
   logic [7:0]  char_in = 8'h00;
   logic [7:0]  attr_in = 8'h00;
   logic        busy;
   logic [11:0] vaddr;
   logic [7:0]  vdata_out;
   logic        vwe;
   logic [7:0]  vdata_in;
   logic [10:0] cursor;

   logic [7:0]  mem [0:4095];
   int          errors = 0;
   int          checks = 0;

   text_console dut (
      .clock(clock), .reset_n(reset_n), .wr(wr), .char_in(char_in), .attr_in(attr_in),
      .busy(busy), .vaddr(vaddr), .vdata_out(vdata_out), .vwe(vwe),
      .vdata_in(vdata_in), .cursor(cursor)
   );

   always #5 clock = ~clock;

   // Video memory: write on the clock edge, read data follows vaddr.
   always @(posedge clock) if (vwe) mem[vaddr] <= vdata_out;
   assign vdata_in = mem[vaddr];

   // Overall time limit so the run can never hang.
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Issue one character and wait (bounded) for the operation to finish.
   task automatic send(input logic [7:0] c, input logic [7:0] a, output int bc, output int wc);
      @(negedge clock); wr = 1'b1; char_in = c; attr_in = a;
      @(negedge clock); wr = 1'b0;
      bc = 0; wc = 0;
      if (vwe) wc++;
      while (busy && bc < 20000) begin
         bc++;
         @(negedge clock);
         if (vwe) wc++;
      end
      checks++;
      if (busy) begin errors++; $display("[TB] FAIL send_timeout code=%h busy still high after %0d cycles", c, bc); end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
      checks++; if (vwe !== 1'b0) begin errors++; $display("[TB] FAIL reset_vwe got=%b want=0", vwe); end
      checks++; if (vaddr !== 12'h000) begin errors++; $display("[TB] FAIL reset_vaddr got=%h want=000", vaddr); end
      checks++; if (vdata_out !== 8'h00) begin errors++; $display("[TB] FAIL reset_vdata got=%h want=00", vdata_out); end
      checks++; if (cursor !== 11'd0) begin errors++; $display("[TB] FAIL reset_cursor got=%0d want=0", cursor); end
      reset_n = 1'b1;
   endtask

   task automatic test_printable();
      @(negedge clock); wr = 1'b1; char_in = 8'h41; attr_in = 8'h17;
      @(negedge clock); wr = 1'b0;
      checks++; if (vwe !== 1'b1) begin errors++; $display("[TB] FAIL putc_vwe got=%b want=1", vwe); end
      checks++; if (vaddr !== 12'h000) begin errors++; $display("[TB] FAIL putc_vaddr got=%h want=000", vaddr); end
      checks++; if (vdata_out !== 8'h41) begin errors++; $display("[TB] FAIL putc_vdata got=%h want=41", vdata_out); end
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL putc_busy got=%b want=1", busy); end
      @(negedge clock);
      checks++; if (vwe !== 1'b1) begin errors++; $display("[TB] FAIL puta_vwe got=%b want=1", vwe); end
      checks++; if (vaddr !== 12'h001) begin errors++; $display("[TB] FAIL puta_vaddr got=%h want=001", vaddr); end
      checks++; if (vdata_out !== 8'h17) begin errors++; $display("[TB] FAIL puta_vdata got=%h want=17", vdata_out); end
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL puta_busy got=%b want=1", busy); end
      @(negedge clock);
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL print_done_busy got=%b want=0", busy); end
      checks++; if (vwe !== 1'b0) begin errors++; $display("[TB] FAIL print_done_vwe got=%b want=0", vwe); end
      checks++; if (cursor !== 11'd1) begin errors++; $display("[TB] FAIL print_cursor got=%0d want=1", cursor); end
      checks++; if (mem[0] !== 8'h41 || mem[1] !== 8'h17) begin errors++; $display("[TB] FAIL print_mem got=%h/%h want=41/17", mem[0], mem[1]); end
   endtask

   task automatic test_cr_bs();
      int bc, wc, wsum;
      send(8'h0A, 8'h07, bc, wc);
      checks++; if (cursor !== 11'd80 || bc != 0) begin errors++; $display("[TB] FAIL lf_nextrow cursor=%0d busy=%0d want 80/0", cursor, bc); end
      for (int i = 0; i < 5; i++) send(8'h61 + 8'(i), 8'h07, bc, wc);
      checks++; if (cursor !== 11'd85) begin errors++; $display("[TB] FAIL cursor_85 got=%0d want=85", cursor); end
      send(8'h0D, 8'h07, bc, wc);
      checks++; if (cursor !== 11'd80) begin errors++; $display("[TB] FAIL cr_cursor got=%0d want=80", cursor); end
      checks++; if (bc != 0 || wc != 0) begin errors++; $display("[TB] FAIL cr_quiet busy=%0d writes=%0d want 0/0", bc, wc); end
      wsum = 0;
      for (int i = 0; i < 6; i++) begin send(8'h08, 8'h07, bc, wc); wsum += wc + bc; end
      checks++; if (cursor !== 11'd74) begin errors++; $display("[TB] FAIL bs6_cursor got=%0d want=74", cursor); end
      checks++; if (wsum != 0) begin errors++; $display("[TB] FAIL bs_quiet activity=%0d want=0", wsum); end
      send(8'h0D, 8'h07, bc, wc);
      checks++; if (cursor !== 11'd0) begin errors++; $display("[TB] FAIL cr_row0 got=%0d want=0", cursor); end
      send(8'h08, 8'h07, bc, wc);
      checks++; if (cursor !== 11'd0 || bc != 0) begin errors++; $display("[TB] FAIL bs_at_zero cursor=%0d busy=%0d want 0/0", cursor, bc); end
      send(8'h01, 8'h07, bc, wc);
      checks++; if (cursor !== 11'd0 || bc != 0 || wc != 0) begin errors++; $display("[TB] FAIL ignored_ctrl cursor=%0d busy=%0d writes=%0d want 0/0/0", cursor, bc, wc); end
   endtask

   task automatic test_clear();
      int bc, wc, bad;
      send(8'h0C, 8'h07, bc, wc);
      checks++; if (bc != 4000) begin errors++; $display("[TB] FAIL clear_cycles got=%0d want=4000", bc); end
      checks++; if (wc != 4000) begin errors++; $display("[TB] FAIL clear_writes got=%0d want=4000", wc); end
      checks++; if (cursor !== 11'd0) begin errors++; $display("[TB] FAIL clear_cursor got=%0d want=0", cursor); end
      bad = 0;
      for (int i = 0; i < 2000; i++) if (mem[2*i] !== 8'h20 || mem[2*i+1] !== 8'h07) bad++;
      checks++; if (bad != 0) begin errors++; $display("[TB] FAIL clear_contents bad_cells=%0d want=0", bad); end
   endtask

   task automatic test_scroll_putc();
      int bc, wc, bad;
      send(8'h0A, 8'h07, bc, wc);
      send(8'h58, 8'h1E, bc, wc);
      send(8'h0D, 8'h07, bc, wc);
      for (int i = 0; i < 23; i++) send(8'h0A, 8'h07, bc, wc);
      checks++; if (cursor !== 11'd1920) begin errors++; $display("[TB] FAIL lf_to_last_row got=%0d want=1920", cursor); end
      for (int i = 0; i < 79; i++) send(8'h30 + 8'(i % 10), 8'h0F, bc, wc);
      checks++; if (cursor !== 11'd1999) begin errors++; $display("[TB] FAIL cursor_1999 got=%0d want=1999", cursor); end
      send(8'h42, 8'h2C, bc, wc);
      checks++; if (bc != 7842) begin errors++; $display("[TB] FAIL scroll_putc_cycles got=%0d want=7842", bc); end
      checks++; if (wc != 4002) begin errors++; $display("[TB] FAIL scroll_putc_writes got=%0d want=4002", wc); end
      checks++; if (cursor !== 11'd1920) begin errors++; $display("[TB] FAIL scroll_cursor got=%0d want=1920", cursor); end
      checks++; if (mem[0] !== 8'h58 || mem[1] !== 8'h1E) begin errors++; $display("[TB] FAIL scroll_row1_up got=%h/%h want=58/1E", mem[0], mem[1]); end
      checks++; if (mem[3838] !== 8'h42 || mem[3839] !== 8'h2C) begin errors++; $display("[TB] FAIL scroll_cell1999_up got=%h/%h want=42/2C", mem[3838], mem[3839]); end
      bad = 0;
      for (int i = 0; i < 79; i++) if (mem[2*(1840+i)] !== 8'h30 + 8'(i % 10) || mem[2*(1840+i)+1] !== 8'h0F) bad++;
      checks++; if (bad != 0) begin errors++; $display("[TB] FAIL scroll_row23 bad_cells=%0d want=0", bad); end
      bad = 0;
      for (int i = 1920; i < 2000; i++) if (mem[2*i] !== 8'h20 || mem[2*i+1] !== 8'h2C) bad++;
      checks++; if (bad != 0) begin errors++; $display("[TB] FAIL scroll_fill bad_cells=%0d want=0", bad); end
   endtask

   task automatic test_lf_scroll();
      int bc, wc, bad;
      for (int i = 0; i < 10; i++) send(8'h50 + 8'(i), 8'h5A, bc, wc);
      checks++; if (cursor !== 11'd1930) begin errors++; $display("[TB] FAIL cursor_1930 got=%0d want=1930", cursor); end
      send(8'h0A, 8'h33, bc, wc);
      checks++; if (bc != 7840 || wc != 4000) begin errors++; $display("[TB] FAIL lf_scroll_timing busy=%0d writes=%0d want 7840/4000", bc, wc); end
      checks++; if (cursor !== 11'd1920) begin errors++; $display("[TB] FAIL lf_scroll_cursor got=%0d want=1920", cursor); end
      bad = 0;
      for (int i = 0; i < 10; i++) if (mem[2*(1840+i)] !== 8'h50 + 8'(i) || mem[2*(1840+i)+1] !== 8'h5A) bad++;
      if (mem[3700] !== 8'h20 || mem[3701] !== 8'h2C) bad++;
      checks++; if (bad != 0) begin errors++; $display("[TB] FAIL lf_scroll_row23 bad_cells=%0d want=0", bad); end
      checks++; if (mem[3678] !== 8'h42) begin errors++; $display("[TB] FAIL lf_scroll_row22 got=%h want=42", mem[3678]); end
      bad = 0;
      for (int i = 1920; i < 2000; i++) if (mem[2*i] !== 8'h20 || mem[2*i+1] !== 8'h33) bad++;
      checks++; if (bad != 0) begin errors++; $display("[TB] FAIL lf_scroll_fill bad_cells=%0d want=0", bad); end
   endtask

   task automatic test_busy_ignore();
      int n, bad;
      @(negedge clock); wr = 1'b1; char_in = 8'h0C; attr_in = 8'h07;
      @(negedge clock); wr = 1'b0;
      for (int p = 0; p < 5; p++) begin
         repeat (37) @(negedge clock);
         wr = 1'b1; char_in = 8'h5A; attr_in = 8'h99;
         @(negedge clock); wr = 1'b0;
      end
      n = 0;
      while (busy && n < 20000) begin n++; @(negedge clock); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ignore_timeout busy=%b want=0", busy); end
      checks++; if (cursor !== 11'd0) begin errors++; $display("[TB] FAIL ignore_cursor got=%0d want=0", cursor); end
      bad = 0;
      for (int i = 0; i < 2000; i++) if (mem[2*i] !== 8'h20 || mem[2*i+1] !== 8'h07) bad++;
      checks++; if (bad != 0) begin errors++; $display("[TB] FAIL ignore_contents bad_cells=%0d want=0", bad); end
   endtask

   task automatic test_reset_mid();
      int bc, wc;
      send(8'h51, 8'h07, bc, wc);
      for (int i = 0; i < 24; i++) send(8'h0A, 8'h07, bc, wc);
      checks++; if (cursor !== 11'd1920) begin errors++; $display("[TB] FAIL mid_setup_cursor got=%0d want=1920", cursor); end
      @(negedge clock); wr = 1'b1; char_in = 8'h0A; attr_in = 8'h44;
      @(negedge clock); wr = 1'b0;
      repeat (200) @(negedge clock);
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL mid_scroll_busy got=%b want=1", busy); end
      #2 reset_n = 1'b0;
      #1;
      checks++; if (vwe !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_outputs vwe=%b busy=%b want 0/0", vwe, busy); end
      checks++; if (cursor !== 11'd0 || vaddr !== 12'h000) begin errors++; $display("[TB] FAIL mid_reset_state cursor=%0d vaddr=%h want 0/000", cursor, vaddr); end
      @(negedge clock); reset_n = 1'b1;
      send(8'h43, 8'h07, bc, wc);
      checks++; if (bc != 2 || cursor !== 11'd1 || mem[0] !== 8'h43) begin errors++; $display("[TB] FAIL after_reset_print busy=%0d cursor=%0d mem0=%h want 2/1/43", bc, cursor, mem[0]); end
   endtask

   initial begin
      test_reset();
      test_printable();
      test_cr_bs();
      test_clear();
      test_scroll_putc();
      test_lf_scroll();
      test_busy_ignore();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/text_console.md
TEXT_CONSOLE -- requirements
Module: text_console

Interface
REQ-001 Parameters SHALL be:
- COLS, 80, characters per row.
- ROWS, 25, rows per screen.
- BLANK, 8'h20, fill character for scroll and clear.
- Port widths are sized for the default values.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clock  in  1  sole clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous reset, active-low.
- wr  in  1  single-cycle character strobe.
- char_in  in  8  character code.
- attr_in  in  8  attribute byte for the character.
- busy  out  1  high while a memory sequence is in progress.
- vaddr  out  12  video memory byte address.
- vdata_out  out  8  video memory write data.
- vwe  out  1  video memory write enable.
- vdata_in  in  8  video memory read data, valid one cycle after vaddr.
- cursor  out  11  cursor cell index, 0..COLS*ROWS-1.

REQ-003 This block SHALL be the producer of the text-mode video memory:
- Cell i holds its character at byte 2i and its attribute at byte 2i+1.
- The cursor output feeds the text display adapter directly.

Function
REQ-004 wr SHALL be accepted only when busy=0 at the clock edge; wr while busy=1 SHALL be ignored with no side effects.
REQ-005 On accept, char_in and attr_in SHALL be latched; all later writes of the operation use the latched values.
REQ-006 State machine states SHALL be IDLE, PUTC, PUTA, SRD, SWR, FILC, FILA; busy SHALL equal (state != IDLE).
REQ-007 vaddr, vdata_out and vwe SHALL be registered; vwe=0 in IDLE, SRD and in any state not listed as writing.
REQ-008 Printable code (char_in >= 8'h20) SHALL proceed as follows:
- IDLE->PUTC: vwe=1, vaddr=2*cursor, vdata_out=char.
- PUTC->PUTA: vwe=1, vaddr=2*cursor+1, vdata_out=attr.
- After PUTA, cursor increments and state returns to IDLE.
- If the incremented cursor equals COLS*ROWS, scroll instead (REQ-012).
REQ-009 8'h0D (CR) SHALL set cursor to COLS*(cursor/COLS) on the accept edge, with no memory write and busy staying low.
REQ-010 8'h0A (LF) SHALL act as follows:
- If row < ROWS-1, set cursor to the start of the next row on the accept edge, with busy staying low.
- If row = ROWS-1, scroll.
REQ-011 8'h08 (BS) SHALL decrement cursor if nonzero and otherwise leave it at 0; no erase, no memory write.
REQ-012 Scroll SHALL run in three parts:
- Copy phase: for byte index k = 0 .. 2*COLS*(ROWS-1)-1, SRD drives vaddr=k+2*COLS with vwe=0; the next cycle SWR drives vaddr=k, vdata_out=vdata_in, vwe=1.
- Fill phase: FILC/FILA write BLANK and the latched attr to every cell of the last row (one byte per cycle).
- End: cursor = COLS*(ROWS-1), state returns to IDLE.
REQ-013 8'h0C (FF) SHALL clear the screen:
- FILC/FILA write BLANK/attr to all COLS*ROWS cells from cell 0 upward, one byte per cycle.
- Then cursor=0 and state returns to IDLE.
REQ-014 Other codes below 8'h20 SHALL be ignored: no write, no cursor change, busy stays low.
REQ-015 Cycle counts from the accept edge to busy falling SHALL be:
- Printable, no scroll: 2 cycles.
- Scroll: 2*2*COLS*(ROWS-1) + 2*COLS cycles, i.e. 7840 at defaults.
- Clear: 2*COLS*ROWS cycles, i.e. 4000 at defaults.
REQ-016 Cursor arithmetic SHALL never exceed COLS*ROWS-1 at the output; no wrap to 0 is permitted except through FF.

Reset
REQ-017 reset_n=0 SHALL asynchronously force the following, with no write issued during reset:
- state=IDLE, cursor=0, busy=0.
- vwe=0, vaddr=0, vdata_out=0.
- latched char/attr = 0.
REQ-018 Reset asserted mid-scroll or mid-clear SHALL abort the operation immediately; video memory contents are not restored.
REQ-019 Video memory is not cleared by reset; software issues FF.

Verification
REQ-020 After reset, wr char 8'h41 attr 8'h17 -> write 8'h41 at 12'h000, then 8'h17 at 12'h001 on consecutive cycles; busy high 2 cycles; cursor=1.
REQ-021 Cursor=85, CR -> cursor=80 with no vwe; then BS x6 -> cursor=74; cursor=0, BS -> cursor stays 0.
REQ-022 Cursor=1999, wr 8'h42 -> cell 1999 written, then scroll:
- Bytes previously at 160..161 appear at 0..1.
- Cells 1920..1999 = 8'h20/attr.
- cursor=1920; busy for 2+7840 cycles.
REQ-023 Cursor=1930, LF -> scroll; cursor=1920; old row 24 contents found in row 23.
REQ-024 FF with attr 8'h07 -> all 4000 bytes written as 20/07 pairs; cursor=0; busy exactly 4000 cycles.
REQ-025 Stimulus while busy and mid-operation reset:
- wr pulses while busy -> no effect on memory or cursor.
- reset_n low at copy cycle 100 -> vwe=0, busy=0, cursor=0 immediately.
